// File: rtl/instruction_loader.sv
// Purpose: UART (8N1) boot loader; packs received bytes little-endian into words and writes instruction memory.
// Latency: a word write strobes the cycle after the byte that completes it; release follows the final write by one cycle.
// Backpressure: none; the UART cannot be stalled, so each byte is consumed in its valid cycle.
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing mod-256 payload checksum byte.
module instruction_loader #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int MEM_BYTES   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [31:0] byte_address,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic        load_active,
    output logic        load_done,
    output logic        frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        LD_HEADER,
        LD_PAYLOAD,
        LD_FINISH,
`ifdef LOADER_CHECKSUM_EN
        LD_CHECK,
`endif
        LD_DONE
    } ld_state_t;

    // ---------------- line synchronizer ----------------
    logic rx_meta, rx_sync;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             byte_vld, byte_vld_nxt;
    logic             stop_err;

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            byte_vld <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            byte_vld <= byte_vld_nxt;
        end
    end

    // Receiver next state: mid-bit sampling driven by a per-bit clock counter.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        byte_vld_nxt = 1'b0;
        stop_err     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (!rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    // A line already back high was only a glitch.
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) byte_vld_nxt = 1'b1;
                    else         stop_err     = 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- loader ----------------
    ld_state_t   ld_state, ld_state_nxt;
    logic [1:0]  hdr_cnt, hdr_cnt_nxt;
    logic [31:0] len, len_nxt;
    logic [31:0] count, count_nxt;
    logic [31:0] word_buf, buf_nxt;
    logic [31:0] merged;
    logic        last_byte;
    logic        we_nxt;
    logic [31:0] wdata_nxt, waddr_nxt;
    logic        chk_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum, sum_nxt;

    // Running payload checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum <= '0;
        else     sum <= sum_nxt;
    end
`endif

    // Loader state, counters and the memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state     <= LD_HEADER;
            hdr_cnt      <= '0;
            len          <= '0;
            count        <= '0;
            word_buf     <= '0;
            write_enable <= 1'b0;
            write_data   <= '0;
            byte_address <= '0;
        end else begin
            ld_state     <= ld_state_nxt;
            hdr_cnt      <= hdr_cnt_nxt;
            len          <= len_nxt;
            count        <= count_nxt;
            word_buf     <= buf_nxt;
            write_enable <= we_nxt;
            write_data   <= wdata_nxt;
            byte_address <= waddr_nxt;
        end
    end

    // Loader next state: header length capture, lane packing, word writes, release.
    always_comb begin
        ld_state_nxt = ld_state;
        hdr_cnt_nxt  = hdr_cnt;
        len_nxt      = len;
        count_nxt    = count;
        buf_nxt      = word_buf;
        we_nxt       = 1'b0;
        wdata_nxt    = write_data;
        waddr_nxt    = byte_address;
        chk_err      = 1'b0;
        merged       = word_buf | (32'(rx_shift) << {count[1:0], 3'b000});
        last_byte    = ((count + 32'd1) == len);
`ifdef LOADER_CHECKSUM_EN
        sum_nxt      = sum;
`endif
        case (ld_state)
            LD_HEADER: begin
                if (byte_vld) begin
                    len_nxt     = {rx_shift, len[31:8]};
                    hdr_cnt_nxt = hdr_cnt + 2'd1;
                    if (hdr_cnt == 2'd3) begin
                        if (len_nxt != 32'd0) ld_state_nxt = LD_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
                        else                  ld_state_nxt = LD_CHECK;
`else
                        else                  ld_state_nxt = LD_DONE;
`endif
                    end
                end
            end
            LD_PAYLOAD: begin
                if (byte_vld) begin
                    count_nxt = count + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt   = sum + rx_shift;
`endif
                    if (count[1:0] == 2'd3 || last_byte) begin
                        buf_nxt = '0;
                        // Bytes beyond the memory are consumed but never written.
                        if (count < MEM_LIMIT) begin
                            we_nxt    = 1'b1;
                            wdata_nxt = merged;
                            waddr_nxt = {count[31:2], 2'b00};
                        end
                    end else begin
                        buf_nxt = merged;
                    end
                    if (last_byte) ld_state_nxt = LD_FINISH;
                end
            end
            LD_FINISH: begin
                // Occupied during the final write so release lands one cycle later.
`ifdef LOADER_CHECKSUM_EN
                ld_state_nxt = LD_CHECK;
`else
                ld_state_nxt = LD_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            LD_CHECK: begin
                if (byte_vld) begin
                    chk_err      = (rx_shift != sum);
                    ld_state_nxt = LD_DONE;
                end
            end
`endif
            LD_DONE: ;
            default: ld_state_nxt = LD_HEADER;
        endcase
    end

    // Sticky error flag; framing errors after release are ignored with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 frame_error <= 1'b0;
        else if ((stop_err && ld_state != LD_DONE) || chk_err)   frame_error <= 1'b1;
    end

    assign load_done   = (ld_state == LD_DONE);
    assign load_active = (ld_state != LD_DONE);

endmodule
